// File: rtl/pll_lock_supervisor.sv
// PLL supervisor and reset sequencer: holds the PLL in reset, qualifies lock
// over a stability window, then releases NUM_DOMAINS resets in fixed order.
`timescale 1ns/1ps
module pll_lock_supervisor #(
   parameter int unsigned NUM_DOMAINS        = 3,
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned RELOCK_TIMEOUT     = 65536,
   parameter int unsigned RELEASE_GAP        = 8,
   parameter int unsigned CNT_W              = 8
) (
   input  logic                   refclk,
   input  logic                   rst,
   input  logic                   locked,
   input  logic                   clear_stats,
   output logic                   pll_rst,
   output logic [NUM_DOMAINS-1:0] domain_rst,
   output logic                   ready,
   output logic [CNT_W-1:0]       lock_loss_count,
   output logic [CNT_W-1:0]       retry_count,
   output logic                   timeout_err
);

   localparam int unsigned CMAX0 = (RELOCK_TIMEOUT > PLL_RST_CYCLES) ? RELOCK_TIMEOUT : PLL_RST_CYCLES;
   localparam int unsigned CMAX  = (CMAX0 > RELEASE_GAP) ? CMAX0 : RELEASE_GAP;
   localparam int unsigned CW    = $clog2(CMAX + 1);
   localparam int unsigned SW    = $clog2(LOCK_STABLE_CYCLES + 1);
   localparam int unsigned IW    = $clog2(NUM_DOMAINS + 1);

   typedef enum logic [1:0] {ST_PLLRST, ST_WAIT, ST_RELEASE, ST_RUN} state_t;

   state_t                 r_state, w_state;
   logic                   r_sync1, r_lock_s;
   logic [CW-1:0]          r_cnt, w_cnt;
   logic [SW-1:0]          r_stable, w_stable;
   logic [IW-1:0]          r_idx, w_idx;
   logic                   r_pll_rst, w_pll_rst;
   logic [NUM_DOMAINS-1:0] r_domain_rst, w_domain_rst;
   logic                   r_ready, w_ready;
   logic [CNT_W-1:0]       r_loss_cnt, w_loss_cnt;
   logic [CNT_W-1:0]       r_retry_cnt, w_retry_cnt;
   logic                   r_timeout_err, w_timeout_err;
   logic                   w_loss_evt, w_tmo_evt;

   always_comb begin
      w_state      = r_state;
      w_cnt        = r_cnt;
      w_stable     = r_stable;
      w_idx        = r_idx;
      w_domain_rst = r_domain_rst;
      w_ready      = r_ready;
      w_loss_evt   = 1'b0;
      w_tmo_evt    = 1'b0;

      case (r_state)
         // Reset leaves r_cnt at 0 so the hold ends PLL_RST_CYCLES edges after rst
         // drops; re-entry from a retry starts at 1 because the entry edge counts.
         ST_PLLRST: begin
            w_domain_rst = '1;
            w_ready      = 1'b0;
            if (r_cnt == CW'(PLL_RST_CYCLES)) begin
               w_state  = ST_WAIT;
               w_cnt    = '0;
               w_stable = '0;
            end else begin
               w_cnt = r_cnt + 1'b1;
            end
         end
         ST_WAIT: begin
            w_stable = r_lock_s ? r_stable + 1'b1 : '0;
            w_cnt    = r_cnt + 1'b1;
            if (r_lock_s && (r_stable == SW'(LOCK_STABLE_CYCLES - 1))) begin
               w_state         = ST_RELEASE;
               w_cnt           = '0;
               w_idx           = IW'(1);
               w_domain_rst[0] = 1'b0;
            end else if (r_cnt == CW'(RELOCK_TIMEOUT - 1)) begin
               w_state   = ST_PLLRST;
               w_cnt     = CW'(1);
               w_tmo_evt = 1'b1;
            end
         end
         ST_RELEASE, ST_RUN: begin
            if (!r_lock_s) begin
               w_loss_evt   = 1'b1;
               w_state      = ST_PLLRST;
               w_cnt        = CW'(1);
               w_domain_rst = '1;
               w_ready      = 1'b0;
            end else if (r_state == ST_RELEASE) begin
               if (r_cnt == CW'(RELEASE_GAP - 1)) begin
                  w_cnt = '0;
                  if (r_idx == IW'(NUM_DOMAINS)) begin
                     w_state = ST_RUN;
                     w_ready = 1'b1;
                  end else begin
                     for (int unsigned i = 0; i < NUM_DOMAINS; i++) begin
                        if (r_idx == IW'(i)) w_domain_rst[i] = 1'b0;
                     end
                     w_idx = r_idx + 1'b1;
                  end
               end else begin
                  w_cnt = r_cnt + 1'b1;
               end
            end
         end
         default: w_state = ST_PLLRST;
      endcase

      w_pll_rst = (w_state == ST_PLLRST);

      w_loss_cnt    = r_loss_cnt;
      w_retry_cnt   = r_retry_cnt;
      w_timeout_err = r_timeout_err;
      if (clear_stats) begin
         w_loss_cnt    = '0;
         w_retry_cnt   = '0;
         w_timeout_err = 1'b0;
      end else begin
         if (w_loss_evt && (r_loss_cnt != '1)) w_loss_cnt = r_loss_cnt + 1'b1;
         if (w_tmo_evt) begin
            w_timeout_err = 1'b1;
            if (r_retry_cnt != '1) w_retry_cnt = r_retry_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         r_state       <= ST_PLLRST;
         r_sync1       <= 1'b0;
         r_lock_s      <= 1'b0;
         r_cnt         <= '0;
         r_stable      <= '0;
         r_idx         <= '0;
         r_pll_rst     <= 1'b1;
         r_domain_rst  <= '1;
         r_ready       <= 1'b0;
         r_loss_cnt    <= '0;
         r_retry_cnt   <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         r_state       <= w_state;
         r_sync1       <= locked;
         r_lock_s      <= r_sync1;
         r_cnt         <= w_cnt;
         r_stable      <= w_stable;
         r_idx         <= w_idx;
         r_pll_rst     <= w_pll_rst;
         r_domain_rst  <= w_domain_rst;
         r_ready       <= w_ready;
         r_loss_cnt    <= w_loss_cnt;
         r_retry_cnt   <= w_retry_cnt;
         r_timeout_err <= w_timeout_err;
      end
   end

   assign pll_rst         = r_pll_rst;
   assign domain_rst      = r_domain_rst;
   assign ready           = r_ready;
   assign lock_loss_count = r_loss_cnt;
   assign retry_count     = r_retry_cnt;
   assign timeout_err     = r_timeout_err;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: directed timing scenarios plus
// randomized lock waveforms compared against a phase/elapsed-time model.
`timescale 1ns/1ps
module tb_pll_lock_supervisor;

   localparam int P = 4;
   localparam int L = 8;
   localparam int G = 2;
   localparam int N = 3;
   localparam int T = 32;

   logic       refclk = 1'b0;
   logic       rst = 1'b1;
   logic       locked = 1'b0;
   logic       clear_stats = 1'b0;
   logic       pll_rst;
   logic [2:0] domain_rst;
   logic       ready;
   logic [3:0] lock_loss_count;
   logic [3:0] retry_count;
   logic       timeout_err;

   int checks = 0;
   int failures = 0;

   pll_lock_supervisor #(
      .NUM_DOMAINS(N), .PLL_RST_CYCLES(P), .LOCK_STABLE_CYCLES(L),
      .RELOCK_TIMEOUT(T), .RELEASE_GAP(G), .CNT_W(4)
   ) dut (
      .refclk(refclk), .rst(rst), .locked(locked), .clear_stats(clear_stats),
      .pll_rst(pll_rst), .domain_rst(domain_rst), .ready(ready),
      .lock_loss_count(lock_loss_count), .retry_count(retry_count),
      .timeout_err(timeout_err)
   );

   always #5 refclk = ~refclk;

   // Reference model: phase 0 = PLL held, 1 = waiting for lock, 2 = releasing/running.
   // m_t counts edges since the phase began; outputs follow arithmetically from it.
   int         m_phase, m_t, m_stab, m_hold_len;
   logic [1:0] m_lk;
   logic [3:0] m_loss, m_retry;
   logic       m_err;

   always @(posedge refclk) begin
      bit ls, loss, tmo;
      if (rst) begin
         m_phase = 0; m_t = 0; m_stab = 0; m_hold_len = P + 1;
         m_lk = 2'b00; m_loss = 0; m_retry = 0; m_err = 0;
      end else begin
         ls = m_lk[1]; loss = 0; tmo = 0;
         if (m_phase == 0) begin
            m_t++;
            if (m_t == m_hold_len) begin m_phase = 1; m_t = 0; m_stab = 0; end
         end else if (m_phase == 1) begin
            m_t++;
            m_stab = ls ? m_stab + 1 : 0;
            if (m_stab == L) begin m_phase = 2; m_t = 0; end
            else if (m_t == T) begin tmo = 1; m_phase = 0; m_t = 0; m_hold_len = P; end
         end else begin
            if (!ls) begin loss = 1; m_phase = 0; m_t = 0; m_hold_len = P; end
            else if (m_t < G * N) m_t++;
         end
         if (clear_stats) begin
            m_loss = 0; m_retry = 0; m_err = 0;
         end else begin
            if (loss && m_loss != 4'd15) m_loss++;
            if (tmo) begin m_err = 1; if (m_retry != 4'd15) m_retry++; end
         end
         m_lk = {m_lk[0], locked};
      end
   end

   function automatic logic [13:0] model_outputs();
      logic [2:0] d;
      for (int i = 0; i < N; i++) d[i] = (m_phase != 2) || (G * i > m_t);
      return {m_phase == 0, d, (m_phase == 2) && (m_t >= G * N), m_loss, m_retry, m_err};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge refclk);
      #1;
   endtask

   task automatic start_clean();
      rst = 1'b1;
      tick(2);
      rst = 1'b0;
   endtask

   task automatic wait_ready(input string name, input int limit);
      for (int i = 0; i < limit && ready !== 1'b1; i++) tick(1);
      checks++;
      if (ready !== 1'b1) begin
         failures++;
         $display("FAIL %s: ready got %b required 1 within %0d cycles", name, ready, limit);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; locked = 1'b1; clear_stats = 1'b0;
      tick(3);
      checks++;
      if (pll_rst !== 1'b1) begin failures++; $display("FAIL reset_pll_rst: got %b required 1", pll_rst); end
      checks++;
      if (domain_rst !== 3'b111) begin failures++; $display("FAIL reset_domain_rst: got %b required 111", domain_rst); end
      checks++;
      if ({ready, lock_loss_count, retry_count, timeout_err} !== 10'd0)
         begin failures++; $display("FAIL reset_status: got %b required 0", {ready, lock_loss_count, retry_count, timeout_err}); end
   endtask

   task automatic test_bringup();
      logic [2:0] exp_dom;
      rst = 1'b0;
      for (int k = 0; k <= 20; k++) begin
         tick(1);
         exp_dom = (k < 12) ? 3'b111 : (k < 14) ? 3'b110 : (k < 16) ? 3'b100 : 3'b000;
         checks++;
         if (pll_rst !== (k < P)) begin failures++; $display("FAIL bringup_pll_rst@%0d: got %b required %b", k, pll_rst, k < P); end
         checks++;
         if (domain_rst !== exp_dom) begin failures++; $display("FAIL bringup_domain_rst@%0d: got %b required %b", k, domain_rst, exp_dom); end
         checks++;
         if (ready !== (k >= 18)) begin failures++; $display("FAIL bringup_ready@%0d: got %b required %b", k, ready, k >= 18); end
      end
   endtask

   task automatic test_glitch_in_wait();
      int rel = -1;
      locked = 1'b1;
      start_clean();
      for (int k = 0; k <= 26; k++) begin
         tick(1);
         if (k == 9) locked = 1'b0;
         if (k == 10) locked = 1'b1;
         if (rel < 0 && domain_rst[0] === 1'b0) rel = k;
      end
      checks++;
      if (rel != 20) begin failures++; $display("FAIL glitch_release_cycle: got %0d required 20", rel); end
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL glitch_ready@26: got %b required 1", ready); end
      checks++;
      if (lock_loss_count !== 4'd0) begin failures++; $display("FAIL glitch_loss_count: got %0d required 0", lock_loss_count); end
   endtask

   task automatic test_lock_loss_run();
      int highs = 0;
      locked = 1'b1;
      start_clean();
      tick(19);
      checks++;
      if (ready !== 1'b1) begin failures++; $display("FAIL loss_pre_ready: got %b required 1", ready); end
      locked = 1'b0;
      for (int j = 0; j <= 1; j++) begin
         tick(1);
         checks++;
         if ({domain_rst, ready} !== 4'b0001) begin failures++; $display("FAIL loss_hold@%0d: got %b required 0001", j, {domain_rst, ready}); end
      end
      tick(1);
      checks++;
      if ({pll_rst, domain_rst, ready} !== 5'b11110) begin failures++; $display("FAIL loss_response: got %b required 11110", {pll_rst, domain_rst, ready}); end
      checks++;
      if (lock_loss_count !== 4'd1) begin failures++; $display("FAIL loss_count: got %0d required 1", lock_loss_count); end
      locked = 1'b1;
      highs = int'(pll_rst);
      for (int j = 3; j <= 20; j++) begin
         tick(1);
         if (j <= 9) highs += int'(pll_rst);
         if (j == 19 || j == 20) begin
            checks++;
            if (ready !== (j == 20)) begin failures++; $display("FAIL loss_reseq_ready@%0d: got %b required %b", j, ready, j == 20); end
         end
      end
      checks++;
      if (highs != P) begin failures++; $display("FAIL loss_pll_rst_width: got %0d required %0d", highs, P); end
   endtask

   task automatic test_timeout();
      locked = 1'b0;
      start_clean();
      for (int k = 0; k <= 720; k++) begin
         tick(1);
         if (k == 35 || k == 36) begin
            checks++;
            if ({timeout_err, retry_count} !== ((k == 36) ? 5'b10001 : 5'b00000))
               begin failures++; $display("FAIL timeout_first@%0d: got %b required %b", k, {timeout_err, retry_count}, (k == 36) ? 5'b10001 : 5'b00000); end
         end
         if (k == 36 || k == 40) begin
            checks++;
            if (pll_rst !== (k == 36)) begin failures++; $display("FAIL timeout_pll_rst@%0d: got %b required %b", k, pll_rst, k == 36); end
         end
         if (k == 539 || k == 540 || k == 720) begin
            checks++;
            if (retry_count !== ((k == 539) ? 4'd14 : 4'd15)) begin failures++; $display("FAIL timeout_retry_sat@%0d: got %0d required %0d", k, retry_count, (k == 539) ? 14 : 15); end
         end
      end
      checks++;
      if (timeout_err !== 1'b1) begin failures++; $display("FAIL timeout_sticky: got %b required 1", timeout_err); end
   endtask

   task automatic test_clear_coincident();
      locked = 1'b1;
      wait_ready("clear_bringup", 300);
      locked = 1'b0;
      tick(2);
      clear_stats = 1'b1;
      tick(1);
      clear_stats = 1'b0;
      checks++;
      if ({lock_loss_count, retry_count, timeout_err} !== 9'd0)
         begin failures++; $display("FAIL clear_coincident_stats: got %b required 0", {lock_loss_count, retry_count, timeout_err}); end
      checks++;
      if ({pll_rst, domain_rst, ready} !== 5'b11110) begin failures++; $display("FAIL clear_coincident_restart: got %b required 11110", {pll_rst, domain_rst, ready}); end
      locked = 1'b1;
      tick(1);
      checks++;
      if (lock_loss_count !== 4'd0) begin failures++; $display("FAIL clear_stays_zero: got %0d required 0", lock_loss_count); end
   endtask

   task automatic test_rst_mid_release();
      locked = 1'b1;
      wait_ready("rstmid_bringup", 300);
      locked = 1'b0;
      tick(3);
      locked = 1'b1;
      checks++;
      if (lock_loss_count !== 4'd1) begin failures++; $display("FAIL rstmid_loss_pre: got %0d required 1", lock_loss_count); end
      for (int i = 0; i < 100 && domain_rst !== 3'b100; i++) tick(1);
      checks++;
      if (domain_rst !== 3'b100) begin failures++; $display("FAIL rstmid_reach_100: got %b required 100", domain_rst); end
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      checks++;
      if ({pll_rst, domain_rst, ready} !== 5'b11110) begin failures++; $display("FAIL rstmid_outputs: got %b required 11110", {pll_rst, domain_rst, ready}); end
      checks++;
      if ({lock_loss_count, retry_count, timeout_err} !== 9'd0) begin failures++; $display("FAIL rstmid_counters: got %b required 0", {lock_loss_count, retry_count, timeout_err}); end
   endtask

   task automatic test_random();
      int seg = 1;
      logic [13:0] exp_v, got_v;
      for (int c = 0; c < 3000; c++) begin
         seg--;
         if (seg <= 0) begin
            locked = ~locked;
            if (locked) seg = int'($urandom_range(5, 60));
            else seg = ($urandom_range(0, 9) == 0) ? 45 : int'($urandom_range(1, 12));
         end
         clear_stats = ($urandom_range(0, 49) == 0);
         rst = ($urandom_range(0, 499) == 0);
         tick(1);
         exp_v = model_outputs();
         got_v = {pll_rst, domain_rst, ready, lock_loss_count, retry_count, timeout_err};
         checks++;
         if (got_v !== exp_v) begin failures++; $display("FAIL random@%0d: got %b required %b", c, got_v, exp_v); end
      end
      rst = 1'b0;
      clear_stats = 1'b0;
   endtask

   initial begin
      test_reset();
      test_bringup();
      test_glitch_in_wait();
      test_lock_loss_run();
      test_timeout();
      test_clear_coincident();
      test_rst_mid_release();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      failures++;
      $display("FAIL watchdog: got no completion required completion before 2ms");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/pll_lock_supervisor.md
# pll_lock_supervisor

Parametrised PLL supervisor and reset sequencer that sits beside the board PLL on its reference clock. It holds the PLL in reset, qualifies `locked` with a synchroniser and stability window, and releases up to NUM_DOMAINS downstream domain resets in a fixed order. On loss of lock or relock timeout it re-arms automatically and records the event in status counters. It generalises the fixed three-output PLL wrapper into a lock-aware, N-domain reset controller.

## Interface
- NUM_DOMAINS, 3: number of sequenced domain resets (1..16).
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per attempt (>=1).
- LOCK_STABLE_CYCLES, 1024: consecutive synchronised-lock cycles required before release (>=1).
- RELOCK_TIMEOUT, 65536: maximum cycles spent in WAIT before retrying (> LOCK_STABLE_CYCLES).
- RELEASE_GAP, 8: cycles between successive domain releases (>=1).
- CNT_W, 8: width of the status counters.

Ports:
- refclk  in  1  reference clock; all logic runs on it.
- rst  in  1  synchronous, active-high reset.
- locked  in  1  PLL lock, asynchronous; double-flop synchronised internally to `lock_s`.
- clear_stats  in  1  synchronous pulse; clears counters and `timeout_err`.
- pll_rst  out  1  PLL reset, active high.
- domain_rst  out  NUM_DOMAINS  per-domain reset, active high, registered.
- ready  out  1  all domains released and lock held.
- lock_loss_count  out  CNT_W  saturating count of lock losses after release began.
- retry_count  out  CNT_W  saturating count of relock timeouts.
- timeout_err  out  1  sticky; set on any relock timeout.

## Operation
- Reset values: state PLLRST, all counters 0, `pll_rst`=1, `domain_rst`=all ones, `ready`=0, both status counters 0, `timeout_err`=0, synchroniser flops 0.
- PLLRST: `pll_rst`=1 and `domain_rst`=all ones. After PLL_RST_CYCLES cycles, go to WAIT.
- WAIT: `pll_rst`=0. The stable counter increments on each `lock_s`=1 and clears on `lock_s`=0. The timeout counter increments every cycle.
  - When the stable counter reaches LOCK_STABLE_CYCLES, go to RELEASE.
  - Else, when the timeout counter reaches RELOCK_TIMEOUT: set `timeout_err`, increment `retry_count`, go to PLLRST.
  - Stability has priority if both occur in the same cycle.
- RELEASE:
  - `domain_rst[0]` clears on the first RELEASE cycle.
  - `domain_rst[i]` clears RELEASE_GAP*i cycles later.
  - `ready` rises RELEASE_GAP cycles after the last domain clears, with a transition to RUN.
  - Released bits never re-assert except on lock loss or `rst`.
- RUN: `ready`=1. On `lock_s`=0, take the lock-loss action.
- Lock loss (in RELEASE or RUN):
  - Increment `lock_loss_count`.
  - On the next edge: `domain_rst` goes to all ones, `ready`=0, state goes to PLLRST.
- Counters saturate at 2^CNT_W-1.
- `clear_stats` has priority over a same-cycle increment or timeout set. The coincident event is discarded.
- `clear_stats` does not affect state or resets.
- Glitches on `locked` in WAIT restart the stability window but do not count as lock loss.

## Timing
- Cycle 0 is the first edge with `rst`=0.
- `pll_rst` is high through cycle PLL_RST_CYCLES-1 and low from cycle PLL_RST_CYCLES.
- Synchroniser latency is 2 cycles: a `locked` edge is visible in `lock_s` 2 cycles later.
- With `locked` steady high from cycle 0, WAIT entry is at cycle P=PLL_RST_CYCLES, and `lock_s` is already 1 at P.
  - `domain_rst[0]` falls at P+LOCK_STABLE_CYCLES.
  - `domain_rst[i]` falls at P+LOCK_STABLE_CYCLES+RELEASE_GAP*i.
  - `ready` rises at P+LOCK_STABLE_CYCLES+RELEASE_GAP*NUM_DOMAINS.
- A `locked` fall in RUN reaches `lock_s` after 2 cycles. `domain_rst`/`ready` change on the following edge: 3 edges from the pin.
- `rst` asserted mid-sequence forces reset values on the next edge, in any state.
- Timeout: `timeout_err` and the `pll_rst` rise happen RELOCK_TIMEOUT cycles after WAIT entry.

## Test plan
Parameters for all scenarios: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, RELEASE_GAP=2, NUM_DOMAINS=3, RELOCK_TIMEOUT=32, CNT_W=4.

- Clean bring-up, `locked`=1 throughout -> `pll_rst` low at cycle 4; `domain_rst` 111→110 at cycle 12, →100 at 14, →000 at 16; `ready`=1 at cycle 18.
- `locked` low for 1 cycle in WAIT after 5 stable cycles -> window restarts, release delayed by 6+ cycles, `lock_loss_count` stays 0.
- `locked` drops in RUN -> `domain_rst`=111 and `ready`=0 three edges after the pin edge; `lock_loss_count`=1; `pll_rst` high for 4 cycles, then a normal re-sequence.
- `locked` held 0 -> `timeout_err`=1 and `retry_count`=1 at 32 cycles after WAIT entry; after 20 timeouts `retry_count` saturates at 15.
- `clear_stats` pulsed in the same cycle as a lock-loss increment -> `lock_loss_count`=0, `timeout_err`=0, and the sequence still restarts.
- `rst` pulsed during RELEASE with `domain_rst`=100 -> next edge gives `domain_rst`=111, `pll_rst`=1, `ready`=0, and the counters are cleared.
